// File: rtl/mdu_unit.sv
// HI/LO multiply/divide unit for the E stage.
// Fixed-latency busy window; results commit to HI/LO when it closes.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  logic [31:0] hi_tmp;
  logic [31:0] lo_tmp;
  logic        wr_pending;
  logic [3:0]  cnt;

  logic        is_mult;
  logic        is_multu;
  logic        is_div;
  logic        is_divu;
  logic        is_mthi;
  logic        is_mtlo;
  logic        is_arith;
  logic        accept;
  logic        b_zero;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] dvsr;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign busy     = (cnt != 4'd0);
  assign is_arith = is_mult | is_multu | is_div | is_divu;
  assign accept   = start & ~busy & is_arith;

  // one-hot decode of the MDU opcode
  always_comb begin
    is_mult  = 1'b0;
    is_multu = 1'b0;
    is_div   = 1'b0;
    is_divu  = 1'b0;
    is_mthi  = 1'b0;
    is_mtlo  = 1'b0;
    unique case (mdu_op)
      4'd1:    is_mult  = 1'b1;
      4'd2:    is_multu = 1'b1;
      4'd3:    is_div   = 1'b1;
      4'd4:    is_divu  = 1'b1;
      4'd5:    is_mthi  = 1'b1;
      4'd6:    is_mtlo  = 1'b1;
      default: ;
    endcase
  end

  // products: low 64 bits of sign-/zero-extended operands
  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
  end

  // sign-magnitude divide; divisor forced to 1 on zero to keep it defined
  always_comb begin
    b_zero = (b == 32'd0);
    dvsr   = b_zero ? 32'd1 : b;
    abs_a  = a[31] ? -a : a;
    abs_b  = dvsr[31] ? -dvsr : dvsr;
    uq     = abs_a / abs_b;
    ur     = abs_a % abs_b;
    sq     = (a[31] ^ dvsr[31]) ? -uq : uq;
    sr     = a[31] ? -ur : ur;
  end

  // pick the HI/LO result for the accepted op
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    unique case (1'b1)
      is_mult:  {res_hi, res_lo} = prod_s;
      is_multu: {res_hi, res_lo} = prod_u;
      is_div:   {res_hi, res_lo} = {sr, sq};
      is_divu:  {res_hi, res_lo} = {a % dvsr, a / dvsr};
      default:  ;
    endcase
  end

  // accept, count down, commit at window close; mt writes only when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      hi         <= 32'd0;
      lo         <= 32'd0;
      hi_tmp     <= 32'd0;
      lo_tmp     <= 32'd0;
      wr_pending <= 1'b0;
      cnt        <= 4'd0;
    end else if (accept) begin
      hi_tmp     <= res_hi;
      lo_tmp     <= res_lo;
      wr_pending <= ~((is_div | is_divu) & b_zero);
      cnt        <= (is_div | is_divu) ? 4'(DIV_CYCLES)
                                       : 4'(MULT_CYCLES);
    end else if (busy) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        if (wr_pending) begin
          hi <= hi_tmp;
          lo <= lo_tmp;
        end
        wr_pending <= 1'b0;
      end
    end else if (is_mthi) begin
      hi <= a;
    end else if (is_mtlo) begin
      lo <= a;
    end
  end

  // mfhi/mflo read port
  always_comb begin
    mdu_out = 32'd0;
    unique case (mdu_op)
      4'd7:    mdu_out = hi;
      4'd8:    mdu_out = lo;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: directed cases plus random traffic
// against a latency/arithmetic model.
module tb_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_out;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mdu_unit #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES(DC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mdu_op(mdu_op),
    .a(a),
    .b(b),
    .busy(busy),
    .hi(hi),
    .lo(lo),
    .mdu_out(mdu_out)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [31:0] m_hi = 0;
  logic [31:0] m_lo = 0;
  logic [31:0] p_hi = 0;
  logic [31:0] p_lo = 0;
  bit          p_wr = 0;
  int          remaining = 0;
  bit          live = 0;

  // reference model: busy window length + plain 64-bit arithmetic
  initial forever begin
    int sa;
    int sb;
    longint x;
    longint unsigned u;
    @(posedge clk);
    if (reset) begin
      m_hi = 0;
      m_lo = 0;
      remaining = 0;
      live = 1;
    end else if (remaining > 0) begin
      remaining--;
      if (remaining == 0 && p_wr) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (start && mdu_op >= 1 && mdu_op <= 4) begin
      sa = $signed(a);
      sb = $signed(b);
      p_wr = 1;
      case (mdu_op)
        4'd1: begin
          x = longint'(sa) * longint'(sb);
          p_hi = 32'(x >>> 32);
          p_lo = 32'(x);
          remaining = MC;
        end
        4'd2: begin
          u = 64'(a) * 64'(b);
          p_hi = 32'(u >> 32);
          p_lo = 32'(u);
          remaining = MC;
        end
        4'd3: begin
          remaining = DC;
          if (b == 0) p_wr = 0;
          else begin
            p_lo = 32'(longint'(sa) / longint'(sb));
            p_hi = 32'(longint'(sa) % longint'(sb));
          end
        end
        default: begin
          remaining = DC;
          if (b == 0) p_wr = 0;
          else begin
            p_lo = a / b;
            p_hi = a % b;
          end
        end
      endcase
    end else if (mdu_op == 4'd5) begin
      m_hi = a;
    end else if (mdu_op == 4'd6) begin
      m_lo = a;
    end
  end

  // compare every cycle on the falling edge
  initial forever begin
    logic [31:0] eo;
    @(negedge clk);
    if (live) begin
      eo = (mdu_op == 4'd7) ? m_hi : (mdu_op == 4'd8) ? m_lo : 32'd0;
      chk("busy", 32'(busy), 32'(remaining != 0));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("mdu_out", mdu_out, eo);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input logic [3:0] op,
                       input logic [31:0] aa, input logic [31:0] bb);
    start = s;
    mdu_op = op;
    a = aa;
    b = bb;
  endtask

  task automatic run_op(input string nm, input logic [3:0] op,
                        input logic [31:0] aa, input logic [31:0] bb,
                        input int en, input logic [31:0] eh,
                        input logic [31:0] el);
    int n = 0;
    bit stable = 1;
    logic [31:0] h0 = hi;
    logic [31:0] l0 = lo;
    drive(1, op, aa, bb);
    cyc();
    drive(0, 0, 0, 0);
    while (busy && n < 30) begin
      n++;
      if (hi !== h0 || lo !== l0) stable = 0;
      cyc();
    end
    chk({nm, " busy cycles"}, 32'(n), 32'(en));
    chk({nm, " hold"}, 32'(stable), 32'd1);
    chk({nm, " hi"}, hi, eh);
    chk({nm, " lo"}, lo, el);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int n;
    logic [3:0] op;
    bit s;
    reset = 1;
    drive(0, 0, 0, 0);
    cyc();
    cyc();
    reset = 0;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset mdu_out", mdu_out, 32'd0);

    run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 5,
           32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5,
           32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10,
           32'd0, 32'h8000_0000);

    drive(0, 4'd5, 32'h1234, 0);
    cyc();
    drive(0, 4'd6, 32'h5678, 0);
    cyc();
    drive(0, 0, 0, 0);
    run_op("divu zero", 4'd4, 32'd7, 32'd0, 10,
           32'h1234, 32'h5678);
    drive(0, 4'd7, 0, 0);
    #1;
    chk("mfhi", mdu_out, 32'h1234);
    drive(0, 4'd8, 0, 0);
    #1;
    chk("mflo", mdu_out, 32'h5678);
    drive(0, 0, 0, 0);
    cyc();

    drive(1, 4'd4, 32'd100, 32'd7);
    cyc();
    n = 0;
    while (busy && n < 30) begin
      n++;
      if (n == 3) drive(1, 4'd1, 32'd3, 32'd5);
      else drive(0, 0, 0, 0);
      cyc();
    end
    drive(0, 0, 0, 0);
    chk("restart busy cycles", 32'(n), 32'd10);
    chk("restart lo", lo, 32'd14);
    chk("restart hi", hi, 32'd2);

    drive(1, 4'd1, 32'd3, 32'd5);
    cyc();
    drive(0, 0, 0, 0);
    cyc();
    reset = 1;
    cyc();
    reset = 0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    repeat (8) cyc();
    chk("abort late hi", hi, 32'd0);
    chk("abort late lo", lo, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) s = (op >= 1 && op <= 4);
      else s = 1'($urandom_range(0, 1));
      drive(s, op, pick(), pick());
      reset = ($urandom_range(0, 199) == 0);
      cyc();
    end
    reset = 0;
    drive(0, 0, 0, 0);
    repeat (12) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Multiply/divide unit for the E stage of the five-stage MIPS pipeline. Accepts `mult`/`multu`/`div`/`divu` starts and `mthi`/`mtlo` writes, and holds the HI/LO register pair. It serves `mfhi`/`mflo` reads and drives the `busy` flag that the hazard/stall logic consumes. It is the producer side of the start/busy handshake: the stall logic freezes D on `start | busy` for any MDU-class instruction.

## Interface
- `MULT_CYCLES`, 5: busy duration for `mult`/`multu`.
- `DIV_CYCLES`, 10: busy duration for `div`/`divu`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `start`  in  1  E-stage instruction is `mult`/`multu`/`div`/`divu`; same decode the stall logic uses.
- `mdu_op`  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, others treated as none.
- `a`  in  32  forwarded rs value.
- `b`  in  32  forwarded rt value.
- `busy`  out  1  operation in flight.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.
- `mdu_out`  out  32  `hi` when op=7, `lo` when op=8, else 0; combinational.

## Operation
- State: `hi`, `lo`, `hi_tmp`, `lo_tmp`, `wr_pending` (1b), 4-bit down-counter `cnt`; `busy = (cnt != 0)`.
- Accept: at an edge with `start=1`, `busy=0`, op in 1..4:
  - compute the result from `a`/`b`;
  - load `hi_tmp`/`lo_tmp`;
  - set `wr_pending` (cleared for divide-by-zero);
  - load `cnt` with MULT_CYCLES or DIV_CYCLES.
- `start=1` with op outside 1..4: ignored.
- Countdown: `cnt` decrements each edge while nonzero. At the edge where `cnt` goes 1→0, HI/LO take `hi_tmp`/`lo_tmp` if `wr_pending`, then `wr_pending` clears.
- mult: signed 32×32→64; `hi` = [63:32], `lo` = [31:0]. multu: same, unsigned.
- div: `lo` = quotient truncated toward zero; `hi` = remainder, same sign as dividend. 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0. divu: unsigned.
- Divide by zero (b=0, div or divu): full DIV_CYCLES busy window, HI/LO unchanged.
- mthi/mtlo: with `busy=0`, `hi`/`lo` ← `a` at the edge. With `busy=1`, ignored; the stall logic guarantees this never occurs.
- `start` while `busy=1`: ignored, no restart, no counter reload.
- mfhi/mflo read the committed registers only, never `*_tmp`.
- Reset: `hi`=`lo`=0, `hi_tmp`=`lo_tmp`=0, `cnt`=0, `wr_pending`=0, so `busy`=0 and `mdu_out`=0. Reset mid-operation aborts with no commit. Reset wins over any simultaneous start or mt.

## Timing
- Start sampled at edge E0 (end of cycle T). `busy`=1 in cycles T+1..T+N, with N = MULT_CYCLES or DIV_CYCLES.
- New HI/LO visible from cycle T+N+1, the same cycle `busy` first reads 0.
- Back-to-back: a second start may be accepted at the edge ending cycle T+N+1 at the earliest.
- `busy` is registered, never combinational from `start`. The stall logic covers cycle T via `start`.
- `mdu_out` has zero latency from `mdu_op` and the current `hi`/`lo`.

## Test plan
- Reset, then op=1, a=0xFFFFFFFF, b=2:
  - `busy`=1 for exactly 5 cycles;
  - then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE;
  - `hi`/`lo` stay 0 while `busy`=1.
- multu, a=0xFFFFFFFF, b=2 → `hi`=0x00000001, `lo`=0xFFFFFFFE after 5 busy cycles.
- div, a=0xFFFFFFF9 (−7), b=2 → `busy` for 10 cycles, then `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. div, a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- mthi a=0x1234, mtlo a=0x5678, then divu a=7, b=0 → 10 busy cycles, then `hi`=0x1234, `lo`=0x5678; op=7 → `mdu_out`=0x1234, op=8 → 0x5678.
- Start divu 100/7, assert `start` again with mult in busy cycle 3 → no reload, `busy` falls after cycle 10, `lo`=14, `hi`=2.
- Start mult, assert `reset` in busy cycle 2 → next cycle `busy`=0, `hi`=`lo`=0, no later commit.
